// File: rtl/nes_pad_reader_if.sv
// Host and pad-pin signals of the NES/SNES pad reader.
// master drives start and nesd; slave is the reader itself.
interface nes_pad_reader_if;
    logic        start;
    logic        nesd;
    logic        nesc;
    logic        nesl;
    logic        busy;
    logic        done;
    logic [15:0] q;

    modport master (
        output start,
        output nesd,
        input  nesc,
        input  nesl,
        input  busy,
        input  done,
        input  q
    );

    modport slave (
        input  start,
        input  nesd,
        output nesc,
        output nesl,
        output busy,
        output done,
        output q
    );
endinterface

// File: rtl/nes_pad_reader.sv
// Purpose: latch and clock 16 buttons out of an (S)NES pad, publish them on q.
// Latency: start at edge N -> busy from N+1, done/new q 34*HALF_PERIOD cycles later.
// Backpressure: none; start is dropped unless idle, no request is queued.
module nes_pad_reader #(
    parameter int HALF_PERIOD = 150
) (
    input  logic              clk,
    input  logic              reset,
    nes_pad_reader_if.slave   pad
);

    localparam int PW = (2 * HALF_PERIOD > 2) ? $clog2(2 * HALF_PERIOD) : 1;
    localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LOW,
        CLK_HIGH,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] phase;
    logic [3:0]    bit_idx;
    logic [15:0]   shift;
    logic [1:0]    nesd_sync;
    logic [15:0]   q_r;
    logic          nesc_r;
    logic          nesl_r;
    logic          busy_r;
    logic          done_r;
    logic          nesc_nxt;
    logic          nesl_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          half_end;

    assign half_end = (phase == HALF_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pad.start)             state_nxt = LATCH;
            LATCH:    if (phase == LATCH_LAST)   state_nxt = CLK_LOW;
            CLK_LOW:  if (half_end)              state_nxt = CLK_HIGH;
            CLK_HIGH: if (half_end)              state_nxt = (bit_idx == 4'd15) ? DONE : CLK_LOW;
            DONE:                                state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Pin and status flops are loaded from the next state so they line up with it.
    always_comb begin
        nesc_nxt = 1'b1;
        nesl_nxt = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state_nxt)
            LATCH: begin
                nesl_nxt = 1'b1;
                busy_nxt = 1'b1;
            end
            CLK_LOW: begin
                nesc_nxt = 1'b0;
                busy_nxt = 1'b1;
            end
            CLK_HIGH: busy_nxt = 1'b1;
            DONE:     done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            bit_idx   <= 4'd0;
            shift     <= 16'd0;
            nesd_sync <= 2'b11;
            q_r       <= 16'd0;
            nesc_r    <= 1'b1;
            nesl_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            nesd_sync <= {nesd_sync[0], pad.nesd};

            if (state_nxt != state || state == IDLE || state == DONE)
                phase <= '0;
            else
                phase <= phase + 1'b1;

            // Pad data is active-low; capture on the final cycle of the low half.
            if (state == CLK_LOW && half_end)
                shift[bit_idx] <= ~nesd_sync[1];

            if (state == LATCH)
                bit_idx <= 4'd0;
            else if (state == CLK_HIGH && half_end && bit_idx != 4'd15)
                bit_idx <= bit_idx + 4'd1;

            if (state_nxt == DONE)
                q_r <= shift;

            nesc_r <= nesc_nxt;
            nesl_r <= nesl_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
        end
    end

    assign pad.nesc = nesc_r;
    assign pad.nesl = nesl_r;
    assign pad.busy = busy_r;
    assign pad.done = done_r;
    assign pad.q    = q_r;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural 4021-style pad and a q scoreboard.
module tb_nes_pad_reader;

    localparam int HP      = 4;
    localparam int SEQ_LAT = 34 * HP;

    logic clk = 1'b0;
    logic reset;

    nes_pad_reader_if pif();

    nes_pad_reader #(.HALF_PERIOD(HP)) dut (
        .clk   (clk),
        .reset (reset),
        .pad   (pif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    logic [15:0] sb[$];

    logic [15:0] buttons   = 16'h0000;
    logic        glitch    = 1'b0;
    logic        model_bit = 1'b1;
    logic        prev_nesc = 1'b1;
    int          pad_idx   = 0;

    int nesl_cnt   = 0;
    int low_run    = 0;
    int low_pulses = 0;
    int bad_width  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Pad model: latch loads bit 0, each rising nesc advances to the next button.
    always_comb pif.nesd = model_bit ^ glitch;

    always @(negedge clk) begin
        if (pif.nesl)
            pad_idx = 0;
        else if (pif.nesc && !prev_nesc && pad_idx < 16)
            pad_idx++;
        prev_nesc = pif.nesc;
        model_bit = (pad_idx < 16) ? ~buttons[pad_idx[3:0]] : 1'b1;
    end

    // Pin-shape monitor and scoreboard.
    always @(negedge clk) begin
        if (pif.nesl) nesl_cnt++;
        if (!pif.nesc) begin
            low_run++;
        end else if (low_run != 0) begin
            low_pulses++;
            if (low_run != HP) bad_width++;
            low_run = 0;
        end
        if (pif.done) begin
            n_done++;
            check("done_has_request", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("q_at_done", 32'(pif.q), 32'(sb.pop_front()));
        end
    end

    task automatic wait_done(output int dc);
        bit seen;
        seen = 1'b0;
        dc   = -1;
        for (int i = 0; i < SEQ_LAT + 50 && !seen; i++) begin
            @(negedge clk);
            if (pif.done) begin
                seen = 1'b1;
                dc   = cyc;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic launch(input logic [15:0] b, output int sc);
        @(negedge clk);
        buttons   = b;
        sb.push_back(b);
        pif.start = 1'b1;
        @(negedge clk);
        pif.start = 1'b0;
        sc        = cyc;
        check("busy_after_start", 32'(pif.busy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int dc;
        int d0;

        reset     = 1'b1;
        pif.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_nesc", 32'(pif.nesc), 32'd1);
        check("rst_nesl", 32'(pif.nesl), 32'd0);
        check("rst_busy", 32'(pif.busy), 32'd0);
        check("rst_done", 32'(pif.done), 32'd0);
        check("rst_q",    32'(pif.q),    32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Buttons B and bit 11 pressed; check pin shapes and latency.
        nesl_cnt = 0; low_pulses = 0; bad_width = 0; d0 = n_done;
        launch(16'h0801, sc);
        wait_done(dc);
        check("latency_0801", 32'(dc - sc), 32'(SEQ_LAT));
        @(negedge clk);
        check("done_one_cycle", 32'(pif.done), 32'd0);
        check("q_hold_0801", 32'(pif.q), 32'h0801);
        check("nesl_width", 32'(nesl_cnt), 32'(2 * HP));
        check("nesc_pulses", 32'(low_pulses), 32'd16);
        check("nesc_widths_bad", 32'(bad_width), 32'd0);
        check("done_count_0801", 32'(n_done - d0), 32'd1);

        // All released, then all pressed.
        d0 = n_done;
        launch(16'h0000, sc);
        wait_done(dc);
        check("latency_0000", 32'(dc - sc), 32'(SEQ_LAT));
        launch(16'hFFFF, sc);
        wait_done(dc);
        @(negedge clk);
        check("q_ffff", 32'(pif.q), 32'hFFFF);
        check("done_count_pair", 32'(n_done - d0), 32'd2);

        // start held high: ignored while busy and in DONE, accepted in the next idle cycle.
        @(negedge clk);
        buttons = 16'h1234;
        sb.push_back(16'h1234);
        sb.push_back(16'h1234);
        pif.start = 1'b1;
        d0 = n_done;
        @(negedge clk);
        sc = cyc;
        check("busy_held_start", 32'(pif.busy), 32'd1);
        wait_done(dc);
        check("latency_held_start", 32'(dc - sc), 32'(SEQ_LAT));
        check("busy_in_done", 32'(pif.busy), 32'd0);
        @(negedge clk);
        check("idle_after_done", 32'(pif.busy), 32'd0);
        @(negedge clk);
        check("restart_after_done", 32'(pif.busy), 32'd1);
        sc = cyc;
        pif.start = 1'b0;
        wait_done(dc);
        check("latency_restart", 32'(dc - sc), 32'(SEQ_LAT));
        @(negedge clk);
        check("done_count_held", 32'(n_done - d0), 32'd2);

        // Abort in CLK_HIGH of bit 7 after q=00FF.
        launch(16'h00FF, sc);
        wait_done(dc);
        launch(16'h5555, sc);
        while (cyc < sc + 69) @(negedge clk);
        check("pre_abort_nesc", 32'(pif.nesc), 32'd1);
        check("pre_abort_busy", 32'(pif.busy), 32'd1);
        check("pre_abort_q",    32'(pif.q),    32'h00FF);
        reset = 1'b1;
        void'(sb.pop_back());
        d0 = n_done;
        @(negedge clk);
        check("abort_nesc", 32'(pif.nesc), 32'd1);
        check("abort_nesl", 32'(pif.nesl), 32'd0);
        check("abort_busy", 32'(pif.busy), 32'd0);
        check("abort_q",    32'(pif.q),    32'd0);
        check("abort_done", 32'(pif.done), 32'd0);

        // start together with reset is overridden.
        pif.start = 1'b1;
        @(negedge clk);
        check("rst_start_busy", 32'(pif.busy), 32'd0);
        check("rst_start_nesl", 32'(pif.nesl), 32'd0);
        reset     = 1'b0;
        pif.start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(pif.busy), 32'd0);
        check("no_done_after_abort", 32'(n_done - d0), 32'd0);
        launch(16'h8001, sc);
        wait_done(dc);
        check("latency_post_rst", 32'(dc - sc), 32'(SEQ_LAT));

        // One-cycle nesd glitch in the middle of CLK_HIGH of bit 3.
        launch(16'hA5C3, sc);
        while (cyc < sc + 37) @(negedge clk);
        check("glitch_in_clk_high", 32'(pif.nesc), 32'd1);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        wait_done(dc);
        @(negedge clk);
        check("q_after_glitch", 32'(pif.q), 32'hA5C3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
